// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Width of an index into n requesters; at least one bit.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder: first asserted req after rr_ptr, wrapping.
module rr_priority_encoder
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  output logic          found,
  output logic [PW-1:0] index
);

  int idx;

  always_comb begin
    found = 1'b0;
    index = '0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(rr_ptr) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        index = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locking round-robin arbiter feeding one FIFO write port.
//   state | meaning
//   IDLE  | no owner; arbitrate among req_valid, no transfer this cycle
//   LOCK  | grant_id owns the FIFO until last beat or MAX_BURST beats
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_wr_en,
  output logic [DATA_W-1:0]           fifo_wr_data,
  output logic [ptr_w(NUM_REQ)-1:0]   grant_id,
  output logic                        busy,
  output logic                        burst_err
);

  localparam int PW = ptr_w(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t    state, state_nxt;
  logic [PW-1:0] rr_ptr, rr_nxt;
  logic [PW-1:0] gnt_nxt;
  logic [CW-1:0] beat_cnt, cnt_nxt, cnt_inc;
  logic          berr_nxt;
  logic          found;
  logic [PW-1:0] winner;
  logic          accept;

  rr_priority_encoder #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_enc (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .found  (found),
    .index  (winner)
  );

  // Handshake is gated by rst so a packet cut by reset never writes.
  assign accept  = (state == LOCK) && req_valid[grant_id] && !fifo_full && rst;
  assign cnt_inc = beat_cnt + CW'(1);
  assign busy    = (state == LOCK);

  always_comb begin
    req_ready = '0;
    if ((state == LOCK) && !fifo_full && rst)
      req_ready[grant_id] = 1'b1;
  end

  assign fifo_wr_en   = accept;
  assign fifo_wr_data = accept ? req_data[grant_id*DATA_W +: DATA_W] : '0;

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    gnt_nxt   = grant_id;
    cnt_nxt   = beat_cnt;
    berr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = LOCK;
          gnt_nxt   = winner;
          cnt_nxt   = '0;
        end
      end
      LOCK: begin
        if (accept) begin
          cnt_nxt = cnt_inc;
          if (req_last[grant_id]) begin
            state_nxt = IDLE;
            rr_nxt    = grant_id;
          end else if (cnt_inc == CW'(MAX_BURST)) begin
            state_nxt = IDLE;
            rr_nxt    = grant_id;
            berr_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= PW'(NUM_REQ - 1);
      grant_id  <= '0;
      beat_cnt  <= '0;
      burst_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      grant_id  <= gnt_nxt;
      beat_cnt  <= cnt_nxt;
      burst_err <= berr_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with NUM_REQ=4, DATA_W=16, MAX_BURST=4.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        burst_err;

  int cnt  [4];
  int plen [4];
  int vectors     = 0;
  int miscompares = 0;

  fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .DATA_W    (16),
    .MAX_BURST (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .busy         (busy),
    .burst_err    (burst_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] beat(input int i, input int c);
    return {8'(i), 8'(c)};
  endfunction

  // Each requester presents beat {id, count}; last every plen beats (0 = never).
  task automatic settle();
    for (int i = 0; i < 4; i++) begin
      req_data[i*16 +: 16] = beat(i, cnt[i]);
      req_last[i] = (plen[i] != 0) && (((cnt[i] + 1) % plen[i]) == 0);
    end
    #1;
  endtask

  task automatic step();
    logic [3:0] hs;
    hs = req_valid & req_ready;
    @(posedge clk);
    #2;
    for (int i = 0; i < 4; i++)
      if (hs[i]) cnt[i]++;
    settle();
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {busy, fifo_wr_en, req_ready, fifo_wr_data}, 32'h0);
  endtask

  task automatic chk_beat(input string tag, input int owner, input int c);
    chk({tag, "_gnt"},  grant_id, owner);
    chk({tag, "_wr"},   {busy, fifo_wr_en}, 2'b11);
    chk({tag, "_data"}, fifo_wr_data, beat(owner, c));
    chk({tag, "_rdy"},  req_ready, 4'b1 << owner);
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt[i]  = 0;
      plen[i] = 0;
    end
    settle();
    step();
    step();
    chk("rst_state", {busy, fifo_wr_en, req_ready, burst_err}, 32'h0);
    chk("rst_gnt", grant_id, 0);
    rst = 1'b1;
    settle();

    // No requests: stays idle.
    for (int k = 0; k < 10; k++) begin
      chk_idle("t33_idle");
      chk("t33_gnt", grant_id, 0);
      step();
    end

    // Everyone requests 2-beat packets: grants 0,1,2,3,0 with an idle gap.
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) plen[i] = 2;
    settle();
    for (int p = 0; p < 5; p++) begin
      chk_idle("t34_gap");
      chk("t34_hold", grant_id, (p == 0) ? 0 : (p - 1) % 4);
      step();
      for (int b = 0; b < 2; b++) begin
        chk_beat("t34", p % 4, 2 * (p / 4) + b);
        step();
      end
    end
    req_valid = '0;
    settle();
    chk_idle("t34_end");
    step();
    chk_idle("t34_end2");

    // Owner 2 stalled by fifo_full for 5 cycles mid-packet.
    req_valid = 4'b0100;
    cnt[2] = 0;
    plen[2] = 4;
    settle();
    chk_idle("t35_arb");
    step();
    chk_beat("t35_b0", 2, 0);
    step();
    fifo_full = 1'b1;
    settle();
    for (int k = 0; k < 5; k++) begin
      chk("t35_stall", {busy, fifo_wr_en, req_ready, fifo_wr_data}, {2'b10, 4'b0000, 16'h0});
      chk("t35_stall_gnt", grant_id, 2);
      step();
    end
    fifo_full = 1'b0;
    settle();
    for (int b = 1; b < 4; b++) begin
      chk_beat("t35_resume", 2, b);
      step();
    end
    req_valid = '0;
    settle();
    chk_idle("t35_end");

    // Requester 1 streams without last: cut at 4 beats, then requester 2.
    req_valid = 4'b0110;
    cnt[1] = 0;
    plen[1] = 0;
    cnt[2] = 0;
    plen[2] = 2;
    settle();
    chk_idle("t36_arb");
    step();
    for (int b = 0; b < 4; b++) begin
      chk_beat("t36", 1, b);
      chk("t36_berr_lo", burst_err, 1'b0);
      step();
    end
    chk("t36_berr_hi", burst_err, 1'b1);
    chk_idle("t36_release");
    step();
    chk("t36_berr_pulse", burst_err, 1'b0);
    chk_beat("t36_next0", 2, 0);
    step();
    chk_beat("t36_next1", 2, 1);
    step();
    req_valid = '0;
    settle();
    chk_idle("t36_end");
    chk("t36_end_berr", burst_err, 1'b0);

    // Last on beat 4 at MAX_BURST: normal completion.
    req_valid = 4'b0010;
    cnt[1] = 0;
    plen[1] = 4;
    settle();
    chk_idle("t37_arb");
    step();
    for (int b = 0; b < 4; b++) begin
      chk_beat("t37", 1, b);
      step();
    end
    req_valid = '0;
    settle();
    chk("t37_berr", burst_err, 1'b0);
    chk_idle("t37_release");
    step();
    chk("t37_berr2", burst_err, 1'b0);

    // Reset during beat 2 of a 5-beat packet from requester 2.
    req_valid = 4'b0100;
    cnt[2] = 0;
    plen[2] = 5;
    settle();
    chk_idle("t38_arb");
    step();
    chk_beat("t38_b0", 2, 0);
    step();
    chk_beat("t38_b1", 2, 1);
    step();
    rst = 1'b0;
    settle();
    chk("t38_rst_wr", {fifo_wr_en, req_ready}, 5'b0);
    step();
    chk("t38_post", {busy, fifo_wr_en, req_ready, burst_err}, 32'h0);
    chk("t38_post_gnt", grant_id, 0);
    rst = 1'b1;
    req_valid = 4'b0111;
    cnt[0] = 0;
    plen[0] = 1;
    cnt[1] = 0;
    plen[1] = 1;
    settle();
    chk_idle("t38_arb2");
    step();
    chk_beat("t38_regrant", 0, 0);
    step();
    req_valid = '0;
    settle();
    chk_idle("t38_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
